arith_execute_stage: RTL and testbench

- Execute-stage block directly downstream of the arithmetic decoder; consumes decoded op, immediate, register-write enable and source operands.
- Computes the 64-bit arithmetic result and holds it in a registered output slot with valid/ready handshakes on both sides.
- Supports pipeline flush and keeps a count of completed operations.
- Feeds the memory/writeback stage.

---
 rtl/arith_execute_stage.sv | 121 ++++++++++++
 tb/tb_arith_execute_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/arith_execute_stage.sv
// Execute stage for decoded integer ALU ops. The result sits in a single-entry output register with
// valid/ready handshakes on both sides, and the stage supports flush and a completed-op counter.
package arith_execute_pkg;
  typedef logic [63:0] word_t;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_ADDI, OP_XORI, OP_ORI, OP_ANDI,
    OP_ADDW, OP_SUBW, OP_ADDIW,
    OP_LUI, OP_AUIPC,
    OP_SLL, OP_LD, OP_SD, OP_BEQ, OP_JAL, OP_NOP
  } instruction_type;
endpackage

module arith_execute_stage
  import arith_execute_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  instruction_type in_op,
  input  word_t           in_immed,
  input  word_t           in_rs1,
  input  word_t           in_rs2,
  input  word_t           in_pc,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write_enable,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output word_t           out_result,
  output word_t           out_pc,
  output logic [4:0]      out_rd,
  output logic            out_reg_write_enable,
  output logic            out_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           r_state, w_nextState;
  word_t            r_result, r_pc;
  logic [4:0]       r_rd;
  logic             r_wen, r_illegal;
  logic [CNT_W-1:0] r_opCount;

  word_t w_sum, w_diff, w_sumImm, w_result;
  logic  w_legal, w_inXfer, w_outXfer;

  assign out_valid            = (r_state == FULL);
  assign in_ready             = !out_valid || out_ready;
  assign w_inXfer             = in_valid && in_ready && !flush;
  assign w_outXfer            = out_valid && out_ready;
  assign out_result           = r_result;
  assign out_pc               = r_pc;
  assign out_rd               = r_rd;
  assign out_reg_write_enable = r_wen;
  assign out_illegal          = r_illegal;
  assign op_count             = r_opCount;

  assign w_sum    = in_rs1 + in_rs2;
  assign w_diff   = in_rs1 - in_rs2;
  assign w_sumImm = in_rs1 + in_immed;

  // W-suffixed ops keep only the low word of the sum and sign-extend it.
  always_comb begin
    w_result = '0;
    w_legal  = 1'b1;
    case (in_op)
      OP_ADD:   w_result = w_sum;
      OP_SUB:   w_result = w_diff;
      OP_AND:   w_result = in_rs1 & in_rs2;
      OP_OR:    w_result = in_rs1 | in_rs2;
      OP_XOR:   w_result = in_rs1 ^ in_rs2;
      OP_ADDI:  w_result = w_sumImm;
      OP_XORI:  w_result = in_rs1 ^ in_immed;
      OP_ORI:   w_result = in_rs1 | in_immed;
      OP_ANDI:  w_result = in_rs1 & in_immed;
      OP_ADDW:  w_result = {{32{w_sum[31]}}, w_sum[31:0]};
      OP_SUBW:  w_result = {{32{w_diff[31]}}, w_diff[31:0]};
      OP_ADDIW: w_result = {{32{w_sumImm[31]}}, w_sumImm[31:0]};
      OP_LUI:   w_result = in_immed;
      OP_AUIPC: w_result = in_pc + in_immed;
      default:  w_legal  = 1'b0;
    endcase
  end

  // Flush empties the slot regardless of what the handshakes are doing.
  always_comb begin
    w_nextState = r_state;
    if (flush)          w_nextState = EMPTY;
    else if (w_inXfer)  w_nextState = FULL;
    else if (w_outXfer) w_nextState = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_pc      <= '0;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_illegal <= 1'b0;
      r_opCount <= '0;
    end else if (w_inXfer) begin
      r_result  <= w_legal ? w_result : '0;
      r_pc      <= in_pc;
      r_rd      <= in_rd;
      r_wen     <= in_reg_write_enable && (in_rd != 5'd0) && w_legal;
      r_illegal <= !w_legal;
      r_opCount <= r_opCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arith_execute_stage.sv
// Directed bench for arith_execute_stage: arithmetic results, handshake/backpressure, flush,
// write-enable masking, illegal ops, reset mid-operation and counter wrap with a narrow counter.
module tb_arith_execute_stage;
  import arith_execute_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            inValid;
  logic            inReady, inReady2;
  instruction_type inOp;
  word_t           inImmed, inRs1, inRs2, inPc;
  logic [4:0]      inRd;
  logic            inWen;
  logic            flush;
  logic            outValid, outValid2;
  logic            outReady;
  word_t           outResult, outPc, outResult2, outPc2;
  logic [4:0]      outRd, outRd2;
  logic            outWen, outIllegal, outWen2, outIllegal2;
  logic [31:0]     opCount;
  logic [1:0]      opCount2;

  int errorCount = 0;
  int checkCount = 0;

  arith_execute_stage #(.CNT_W(32)) dut (
    .clk(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady), .in_op(inOp),
    .in_immed(inImmed), .in_rs1(inRs1), .in_rs2(inRs2), .in_pc(inPc), .in_rd(inRd),
    .in_reg_write_enable(inWen), .flush(flush), .out_valid(outValid), .out_ready(outReady),
    .out_result(outResult), .out_pc(outPc), .out_rd(outRd), .out_reg_write_enable(outWen),
    .out_illegal(outIllegal), .op_count(opCount)
  );

  arith_execute_stage #(.CNT_W(2)) dutNarrow (
    .clk(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady2), .in_op(inOp),
    .in_immed(inImmed), .in_rs1(inRs1), .in_rs2(inRs2), .in_pc(inPc), .in_rd(inRd),
    .in_reg_write_enable(inWen), .flush(flush), .out_valid(outValid2), .out_ready(outReady),
    .out_result(outResult2), .out_pc(outPc2), .out_rd(outRd2), .out_reg_write_enable(outWen2),
    .out_illegal(outIllegal2), .op_count(opCount2)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input instruction_type op, input word_t rs1,
                               input word_t rs2, input word_t imm, input word_t pc,
                               input logic [4:0] rd, input logic wen);
    inValid = valid;
    inOp    = op;
    inRs1   = rs1;
    inRs2   = rs2;
    inImmed = imm;
    inPc    = pc;
    inRd    = rd;
    inWen   = wen;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    outReady = 1'b1;
    applyStimulus(1'b0, OP_NOP, '0, '0, '0, '0, '0, 1'b0);
    @(negedge clock);
    stepClock();
    stepClock();
    reset = 1'b0;
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_result", outResult, 0);
    checkOutput("rst_pc", outPc, 0);
    checkOutput("rst_rd", outRd, 0);
    checkOutput("rst_wen", outWen, 0);
    checkOutput("rst_illegal", outIllegal, 0);
    checkOutput("rst_count", opCount, 0);
    checkOutput("rst_in_ready", inReady, 1);

    applyStimulus(1'b1, OP_ADDI, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h100, 5'd3, 1'b1);
    stepClock();
    checkOutput("addi_valid", outValid, 1);
    checkOutput("addi_result", outResult, 64'd2);
    checkOutput("addi_wen", outWen, 1);
    checkOutput("addi_rd", outRd, 3);
    checkOutput("addi_pc", outPc, 64'h100);
    checkOutput("addi_count", opCount, 1);

    applyStimulus(1'b1, OP_ADDW, 64'h7FFF_FFFF, 64'd1, 64'd0, 64'h104, 5'd4, 1'b1);
    stepClock();
    checkOutput("addw_result", outResult, 64'hFFFF_FFFF_8000_0000);
    checkOutput("addw_count", opCount, 2);

    applyStimulus(1'b1, OP_SUBW, 64'd0, 64'd1, 64'd0, 64'h108, 5'd4, 1'b1);
    stepClock();
    checkOutput("subw_result", outResult, 64'hFFFF_FFFF_FFFF_FFFF);

    applyStimulus(1'b1, OP_AUIPC, 64'd0, 64'd0, 64'h1000, 64'h8000_0000, 5'd5, 1'b0);
    stepClock();
    checkOutput("auipc_result", outResult, 64'h8000_1000);
    checkOutput("auipc_wen", outWen, 0);
    checkOutput("auipc_count", opCount, 4);

    // Backpressure: stage is FULL with the AUIPC result and downstream stalls.
    outReady = 1'b0;
    applyStimulus(1'b1, OP_ADD, 64'd10, 64'd20, 64'd0, 64'h200, 5'd7, 1'b1);
    #1;
    checkOutput("bp_in_ready", inReady, 0);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("bp_hold_valid", outValid, 1);
      checkOutput("bp_hold_result", outResult, 64'h8000_1000);
      checkOutput("bp_hold_pc", outPc, 64'h8000_0000);
      checkOutput("bp_hold_count", opCount, 4);
      checkOutput("bp_hold_in_ready", inReady, 0);
    end
    outReady = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", inReady, 1);
    stepClock();
    checkOutput("bp_new_result", outResult, 64'd30);
    checkOutput("bp_new_rd", outRd, 7);
    checkOutput("bp_new_count", opCount, 5);

    // Four back-to-back ops with downstream always ready.
    applyStimulus(1'b1, OP_SUB, 64'd10, 64'd3, 64'd0, 64'h300, 5'd8, 1'b1);
    stepClock();
    checkOutput("b2b_sub", outResult, 64'd7);
    checkOutput("b2b_count1", opCount, 6);
    applyStimulus(1'b1, OP_AND, 64'hF0F0, 64'hFF00, 64'd0, 64'h304, 5'd9, 1'b1);
    stepClock();
    checkOutput("b2b_and", outResult, 64'hF000);
    applyStimulus(1'b1, OP_OR, 64'hF0, 64'h0F, 64'd0, 64'h308, 5'd10, 1'b1);
    stepClock();
    checkOutput("b2b_or", outResult, 64'hFF);
    applyStimulus(1'b1, OP_XOR, 64'hFF, 64'h0F, 64'd0, 64'h30C, 5'd11, 1'b1);
    stepClock();
    checkOutput("b2b_xor", outResult, 64'hF0);
    checkOutput("b2b_pc", outPc, 64'h30C);
    checkOutput("b2b_count4", opCount, 9);

    // Flush while FULL with a new instruction offered.
    flush = 1'b1;
    applyStimulus(1'b1, OP_ADD, 64'd1, 64'd1, 64'd0, 64'h400, 5'd12, 1'b1);
    stepClock();
    flush = 1'b0;
    checkOutput("flush_valid", outValid, 0);
    checkOutput("flush_count", opCount, 9);

    applyStimulus(1'b1, OP_ADD, 64'd1, 64'd2, 64'd0, 64'h500, 5'd0, 1'b1);
    stepClock();
    checkOutput("rd0_result", outResult, 64'd3);
    checkOutput("rd0_wen", outWen, 0);
    checkOutput("rd0_count", opCount, 10);

    applyStimulus(1'b1, OP_LD, 64'd5, 64'd6, 64'd7, 64'h504, 5'd4, 1'b1);
    stepClock();
    checkOutput("ill_valid", outValid, 1);
    checkOutput("ill_flag", outIllegal, 1);
    checkOutput("ill_result", outResult, 0);
    checkOutput("ill_wen", outWen, 0);
    checkOutput("ill_count", opCount, 11);

    applyStimulus(1'b1, OP_ORI, 64'hF0, 64'd0, 64'h0F, 64'h508, 5'd6, 1'b1);
    stepClock();
    checkOutput("ori_result", outResult, 64'hFF);
    checkOutput("ori_illegal", outIllegal, 0);
    checkOutput("ori_wen", outWen, 1);
    applyStimulus(1'b1, OP_ANDI, 64'hFF, 64'd0, 64'h3C, 64'h50C, 5'd6, 1'b1);
    stepClock();
    checkOutput("andi_result", outResult, 64'h3C);
    applyStimulus(1'b1, OP_XORI, 64'hFF, 64'd0, 64'h0F, 64'h510, 5'd6, 1'b1);
    stepClock();
    checkOutput("xori_result", outResult, 64'hF0);
    applyStimulus(1'b1, OP_LUI, 64'hDEAD, 64'd0, 64'h1234_5000, 64'h514, 5'd6, 1'b1);
    stepClock();
    checkOutput("lui_result", outResult, 64'h1234_5000);
    applyStimulus(1'b1, OP_ADDIW, 64'h7FFF_FFFF, 64'd0, 64'd1, 64'h518, 5'd6, 1'b1);
    stepClock();
    checkOutput("addiw_result", outResult, 64'hFFFF_FFFF_8000_0000);
    applyStimulus(1'b1, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'h51C, 5'd6, 1'b1);
    stepClock();
    checkOutput("add_wrap_result", outResult, 64'd1);
    checkOutput("add_wrap_count", opCount, 17);

    applyStimulus(1'b0, OP_NOP, '0, '0, '0, '0, '0, 1'b0);
    stepClock();
    checkOutput("drain_valid", outValid, 0);
    checkOutput("drain_count", opCount, 17);

    // Reset while holding a stalled result.
    applyStimulus(1'b1, OP_ADD, 64'd1, 64'd1, 64'd0, 64'h600, 5'd2, 1'b1);
    stepClock();
    checkOutput("pre_rst_valid", outValid, 1);
    outReady = 1'b0;
    applyStimulus(1'b0, OP_NOP, '0, '0, '0, '0, '0, 1'b0);
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    checkOutput("midrst_valid", outValid, 0);
    checkOutput("midrst_in_ready", inReady, 1);
    checkOutput("midrst_result", outResult, 0);
    checkOutput("midrst_count", opCount, 0);

    // Five ops through both instances; the 2-bit counter wraps to 1.
    outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, OP_ADD, 64'(i), 64'd100, 64'd0, 64'h700, 5'd1, 1'b1);
      stepClock();
      checkOutput("wrap_result", outResult, 64'(i + 100));
    end
    applyStimulus(1'b0, OP_NOP, '0, '0, '0, '0, '0, 1'b0);
    stepClock();
    checkOutput("wrap_count32", opCount, 5);
    checkOutput("wrap_count2", opCount2, 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
